// File: rtl/compositor_pkg.sv
// Shared constants and types for the layer compositor.
// Default parameters, colour keys and the layer-index type.
package compositor_pkg;

  localparam int NUM_LAYERS_DEF   = 16;
  localparam int RGB_W_DEF        = 8;
  localparam int FLASH_FRAMES_DEF = 8;

  localparam logic [RGB_W_DEF-1:0] TRANSPARENT = 8'hFF;
  localparam logic [RGB_W_DEF-1:0] FLASH_RGB   = 8'hE0;

  // Index width that stays legal for a single-layer build.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LAYER_IDX_W = idx_w(NUM_LAYERS_DEF);
  typedef logic [LAYER_IDX_W-1:0] layer_idx_t;

endpackage

// File: rtl/prio_encoder.sv
// Combinational priority encoder: lowest set request index wins.
module prio_encoder #(
  parameter int NUM_LAYERS = compositor_pkg::NUM_LAYERS_DEF,
  localparam int IDX_W     = compositor_pkg::idx_w(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS-1:0] req,
  output logic [IDX_W-1:0]      idx,
  output logic                  valid
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    // Walking downward lets the lowest-index request overwrite the others.
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage layer compositor with frame-synchronous enable mask.
// Optional layer flash compiled in with `define LAYER_COMPOSITOR_FLASH_EN.
module layer_compositor #(
  parameter int                NUM_LAYERS   = compositor_pkg::NUM_LAYERS_DEF,
  parameter int                RGB_W        = compositor_pkg::RGB_W_DEF,
  parameter logic [RGB_W-1:0]  TRANSPARENT  = compositor_pkg::TRANSPARENT,
  parameter int                FLASH_FRAMES = compositor_pkg::FLASH_FRAMES_DEF,
  parameter logic [RGB_W-1:0]  FLASH_RGB    = compositor_pkg::FLASH_RGB,
  localparam int               IDX_W        = compositor_pkg::idx_w(NUM_LAYERS)
) (
  input  logic                             clk,
  input  logic                             resetN,
  input  logic                             startOfFrame,
  input  logic [NUM_LAYERS-1:0]            layerDR,
  input  logic [NUM_LAYERS-1:0][RGB_W-1:0] layerRGB,
  input  logic [RGB_W-1:0]                 bgRGB,
  input  logic                             mask_wr,
  input  logic [NUM_LAYERS-1:0]            mask_data,
  input  logic                             flash_req,
  input  logic [IDX_W-1:0]                 flash_layer,
  output logic [RGB_W-1:0]                 RGBOut,
  output logic [IDX_W-1:0]                 winIdx,
  output logic                             winValid
);

  logic [NUM_LAYERS-1:0]            pend_mask;
  logic [NUM_LAYERS-1:0]            act_mask;
  logic [NUM_LAYERS-1:0]            elig;
  logic [NUM_LAYERS-1:0]            s1_elig;
  logic [NUM_LAYERS-1:0][RGB_W-1:0] s1_rgb;
  logic [RGB_W-1:0]                 s1_bg;
  logic [IDX_W-1:0]                 enc_idx;
  logic                             enc_valid;
  logic                             flash_hit;

  // A write coinciding with startOfFrame goes straight to the active mask.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pend_mask <= '1;
      act_mask  <= '1;
    end else begin
      if (mask_wr)
        pend_mask <= mask_data;
      if (startOfFrame)
        act_mask <= mask_wr ? mask_data : pend_mask;
    end
  end

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      elig[i] = layerDR[i] && act_mask[i] && (layerRGB[i] != TRANSPARENT);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      s1_elig <= '0;
      s1_rgb  <= '0;
      s1_bg   <= '0;
    end else begin
      s1_elig <= elig;
      s1_rgb  <= layerRGB;
      s1_bg   <= bgRGB;
    end
  end

  prio_encoder #(.NUM_LAYERS(NUM_LAYERS)) u_prio_encoder (
    .req   (s1_elig),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

`ifdef LAYER_COMPOSITOR_FLASH_EN
  localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

  logic [CNT_W-1:0] flash_cnt;
  logic [IDX_W-1:0] flash_layer_q;

  // A new request always reloads, even on a startOfFrame cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      flash_cnt     <= '0;
      flash_layer_q <= '0;
    end else if (flash_req) begin
      flash_cnt     <= CNT_W'(FLASH_FRAMES);
      flash_layer_q <= flash_layer;
    end else if (startOfFrame && (flash_cnt != '0)) begin
      flash_cnt <= flash_cnt - 1'b1;
    end
  end

  assign flash_hit = (flash_cnt != '0) && flash_cnt[0] && (enc_idx == flash_layer_q);
`else
  logic unused_flash;
  assign unused_flash = ^{flash_req, flash_layer};
  assign flash_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      RGBOut   <= '0;
      winIdx   <= '0;
      winValid <= 1'b0;
    end else begin
      if (!enc_valid)
        RGBOut <= s1_bg;
      else if (flash_hit)
        RGBOut <= FLASH_RGB;
      else
        RGBOut <= s1_rgb[enc_idx];
      winIdx   <= enc_idx;
      winValid <= enc_valid;
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Randomized self-checking bench for layer_compositor against a frame-level model.
module tb_layer_compositor;
  import compositor_pkg::*;

  localparam int NL = 16;
  localparam int W  = 8;

  logic                  clk = 1'b0;
  logic                  resetN;
  logic                  startOfFrame;
  logic [NL-1:0]         layerDR;
  logic [NL-1:0][W-1:0]  layerRGB;
  logic [W-1:0]          bgRGB;
  logic                  mask_wr;
  logic [NL-1:0]         mask_data;
  logic                  flash_req;
  layer_idx_t            flash_layer;
  logic [W-1:0]          RGBOut;
  layer_idx_t            winIdx;
  logic                  winValid;

  layer_compositor dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .layerDR      (layerDR),
    .layerRGB     (layerRGB),
    .bgRGB        (bgRGB),
    .mask_wr      (mask_wr),
    .mask_data    (mask_data),
    .flash_req    (flash_req),
    .flash_layer  (flash_layer),
    .RGBOut       (RGBOut),
    .winIdx       (winIdx),
    .winValid     (winValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] rgb;
    int           idx;
    bit           valid;
  } exp_t;

  exp_t          exp_q[$];
  logic [NL-1:0] m_pend, m_act;
  int            m_cnt, m_flayer;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = '1;
    m_act   = '1;
    m_cnt   = 0;
    m_flayer = 0;
    exp_q.delete();
  endtask

  task automatic idle_inputs();
    startOfFrame = 1'b0;
    layerDR      = '0;
    layerRGB     = '0;
    bgRGB        = '0;
    mask_wr      = 1'b0;
    mask_data    = '0;
    flash_req    = 1'b0;
    flash_layer  = '0;
  endtask

  // Applies current inputs for one pixel, advances the model, then checks
  // the pixel that entered two cycles earlier.
  task automatic step(input string tag);
    exp_t e;
    int   win = -1;
    for (int i = 0; i < NL; i++)
      if (win < 0 && layerDR[i] && m_act[i] && layerRGB[i] != TRANSPARENT) win = i;
    if (mask_wr) m_pend = mask_data;
    if (startOfFrame) m_act = m_pend;
`ifdef LAYER_COMPOSITOR_FLASH_EN
    if (flash_req) begin
      m_cnt    = FLASH_FRAMES_DEF;
      m_flayer = int'(flash_layer);
    end else if (startOfFrame && m_cnt > 0) begin
      m_cnt--;
    end
`endif
    e.valid = (win >= 0);
    e.idx   = (win >= 0) ? win : 0;
    e.rgb   = (win >= 0) ? layerRGB[win] : bgRGB;
    if (e.valid && (m_cnt % 2 == 1) && e.idx == m_flayer) e.rgb = FLASH_RGB;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
    mask_wr      = 1'b0;
    flash_req    = 1'b0;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check({tag, ".rgb"},   32'(RGBOut),   32'(e.rgb));
      check({tag, ".idx"},   32'(winIdx),   32'(e.idx));
      check({tag, ".valid"}, 32'(winValid), 32'(e.valid));
    end
  endtask

  task automatic flush(input string tag);
    idle_inputs();
    for (int i = 0; i < 2; i++) step(tag);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    resetN = 1'b0;
    #12;
    check("reset.rgb",   32'(RGBOut),   32'h0);
    check("reset.idx",   32'(winIdx),   32'h0);
    check("reset.valid", 32'(winValid), 32'h0);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;

    // Two drawers, lower index wins.
    layerDR = 16'h0006; layerRGB[1] = 8'h1C; layerRGB[2] = 8'h03;
    step("prio");
    flush("prio");

    // Transparent key on the only drawer falls through to background.
    idle_inputs();
    layerDR = 16'h0001; layerRGB[0] = 8'hFF; bgRGB = 8'h49;
    step("transp");
    flush("transp");

    // Mask write mid-frame holds off until the next startOfFrame.
    idle_inputs();
    for (int c = 0; c < 12; c++) begin
      layerDR = 16'h0003; layerRGB[0] = 8'h1C; layerRGB[1] = 8'h03; bgRGB = 8'h49;
      if (c == 2) begin mask_wr = 1'b1; mask_data = 16'hFFFE; end
      if (c == 4) begin mask_wr = 1'b1; mask_data = 16'hFFFC; end
      if (c == 6) startOfFrame = 1'b1;
      if (c == 9) begin startOfFrame = 1'b1; mask_wr = 1'b1; mask_data = 16'hFFFF; end
      step("mask");
      if (c == 7) check("mask.held", 32'(RGBOut), 32'h1C);
    end
    flush("mask");

`ifdef LAYER_COMPOSITOR_FLASH_EN
    // Layer 3 flashes on odd counter frames, then settles.
    idle_inputs();
    layerDR = 16'h0008; layerRGB[3] = 8'h03;
    flash_req = 1'b1; flash_layer = 3;
    step("flash");
    for (int f = 0; f < 10; f++)
      for (int c = 0; c < 4; c++) begin
        layerDR = 16'h0008; layerRGB[3] = 8'h03;
        startOfFrame = (c == 0);
        step("flash");
      end
    check("flash.done", 32'(RGBOut), 32'h03);
    flush("flash");
`endif

    // Reset mid-flash with a pending mask.
    idle_inputs();
    layerDR = 16'h0010; layerRGB[4] = 8'h55;
    mask_wr = 1'b1; mask_data = 16'h0000;
    flash_req = 1'b1; flash_layer = 4;
    step("prerst");
    step("prerst");
    #2;
    resetN = 1'b0;
    #1;
    check("rst.rgb",   32'(RGBOut),   32'h0);
    check("rst.valid", 32'(winValid), 32'h0);
    model_reset();
    @(negedge clk);
    resetN = 1'b1;
    idle_inputs();
    layerDR = 16'h0001; layerRGB[0] = 8'h1C; startOfFrame = 1'b1;
    step("postrst");
    check("postrst.lat1", 32'(winValid), 32'h0);
    idle_inputs();
    step("postrst");
    flush("postrst");

    // Randomized traffic with frames of 16 pixels.
    for (int c = 0; c < 800; c++) begin
      startOfFrame = (c % 16 == 0);
      layerDR      = NL'($urandom & $urandom);
      for (int i = 0; i < NL; i++)
        layerRGB[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : W'($urandom_range(0, 255));
      bgRGB = W'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) begin
        mask_wr   = 1'b1;
        mask_data = NL'($urandom | $urandom);
      end
      if ($urandom_range(0, 49) == 0) begin
        flash_req   = 1'b1;
        flash_layer = layer_idx_t'($urandom_range(0, 3));
      end
      step("rand");
    end
    flush("rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/layer_compositor.md
LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 Parameter NUM_LAYERS, default 16, number of drawing layers; index 0 has highest priority.
REQ-002 Parameter RGB_W, default 8, pixel colour width.
REQ-003 Parameter TRANSPARENT, default 8'hFF, colour key treated as not drawing.
REQ-004 Parameter FLASH_FRAMES, default 8, flash duration in frames.
REQ-005 Parameter FLASH_RGB, default 8'hE0, substitute colour during flash-on frames.
REQ-006 clk  in  1  system pixel clock.
REQ-007 resetN  in  1  asynchronous active-low reset.
REQ-008 startOfFrame  in  1  one-cycle pulse at first pixel of each frame.
REQ-009 layerDR  in  NUM_LAYERS  per-layer draw request.
REQ-010 layerRGB  in  NUM_LAYERS x RGB_W  per-layer colour.
REQ-011 bgRGB  in  RGB_W  background colour, lowest priority.
REQ-012 mask_wr  in  1  write strobe for pending layer-enable mask.
REQ-013 mask_data  in  NUM_LAYERS  new enable mask, bit=1 enables layer.
REQ-014 flash_req  in  1  one-cycle request to flash a layer.
REQ-015 flash_layer  in  clog2(NUM_LAYERS)  layer to flash.
REQ-016 RGBOut  out  RGB_W  composited pixel.
REQ-017 winIdx  out  clog2(NUM_LAYERS)  winning layer index, 0 when none.
REQ-018 winValid  out  1  high when a layer (not background) won.

Function
REQ-019 Layer i SHALL be eligible when layerDR[i]=1, active mask bit i=1 and layerRGB[i]!=TRANSPARENT.
REQ-020 Output SHALL be the lowest-index eligible layer's colour, else bgRGB with winValid=0.
REQ-021 Latency SHALL be exactly 2 cycles: stage 1 registers eligibility vector, colours, bgRGB; stage 2 registers encoder result.
REQ-022 Pipeline SHALL accept one pixel every cycle with no stalls.
REQ-023 mask_wr SHALL load pending mask; active mask SHALL copy pending mask only on startOfFrame.
REQ-024 mask_wr and startOfFrame in same cycle: mask_data SHALL become active at that startOfFrame.
REQ-025 Multiple mask_wr within one frame: last write SHALL win.
REQ-026 Mask change SHALL affect eligibility of pixels entering stage 1 on the cycle after the applying startOfFrame.

Reset
REQ-027 Reset SHALL force RGBOut=0, winIdx=0, winValid=0, both pipeline stages to zero, pending and active masks to all ones, flash counter to 0.
REQ-028 Reset asserted mid-frame or mid-flash SHALL abort immediately; no state survives.

Configuration
REQ-029 Macro LAYER_COMPOSITOR_FLASH_EN SHALL compile in the flash feature.
REQ-030 With macro: flash_req SHALL load counter=FLASH_FRAMES and latch flash_layer; counter SHALL decrement on each startOfFrame while nonzero.
REQ-031 With macro: while counter nonzero and counter bit0=1, winning pixels of latched layer SHALL output FLASH_RGB; winIdx/winValid unchanged.
REQ-032 With macro: flash_req coincident with startOfFrame SHALL reload (no decrement); new flash_req during active flash SHALL restart with new layer.
REQ-033 Without macro: flash_req and flash_layer SHALL be ignored, no counter logic synthesised, outputs identical to flash counter permanently 0.

Structure
REQ-034 Package compositor_pkg SHALL hold default parameter constants, TRANSPARENT, FLASH_RGB and the layer-index typedef.
REQ-035 Sub-module prio_encoder (parametrised NUM_LAYERS, combinational lowest-index-first, outputs index and valid) SHALL be instantiated between stages.

Verification
REQ-036 layerDR=16'h0006, layerRGB[1]=8'h1C, layerRGB[2]=8'h03 -> two cycles later RGBOut=8'h1C, winIdx=1, winValid=1.
REQ-037 layerDR=16'h0001, layerRGB[0]=8'hFF, bgRGB=8'h49 -> RGBOut=8'h49, winValid=0.
REQ-038 mask_wr with mask_data=16'hFFFE mid-frame, layer 0 drawing 8'h1C -> unchanged until next startOfFrame, then lower layer or background shown.
REQ-039 FLASH_EN: flash_req, flash_layer=3, layer 3 sole drawer 8'h03 -> frames with odd counter show 8'hE0, others 8'h03; after 8 startOfFrame pulses always 8'h03.
REQ-040 resetN low during active flash and pending mask -> outputs 0 immediately; after release mask all ones, no flash, first valid pixel 2 cycles after input.
